// File: rtl/speech_cmd_scheduler.sv
// speech_cmd_scheduler: buffers CPC speech-port writes in a small FIFO and hands them to the ATmega one byte at a time over a 4-phase REQ/ACK handshake.
// Latency: 3 cycles from the synchronized strobe edge to REQ high when the FIFO is empty, plus SYNC_STAGES cycles of input synchronization.
// Backpressure: a full FIFO drops new bytes and sets a sticky overflow flag. A pop in the same cycle frees a slot, so that write is still accepted.
//
// Ports:
//   iCPC_CLOCK, iRESET      clock, asynchronous active-high reset
//   iWR_STROBE, iCPC_DATA   decoded speech-port write (async) and CPC data bus
//   iSTATUS_CLEAR           one-cycle pulse that clears the sticky flags
//   iATMEGA_ACK/READY       ATmega handshake acknowledge and ready (async)
//   oATMEGA_DATA/REQ        byte and request presented to the ATmega
//   oFIFO_FULL, oSTATUS     registered full flag and CPC status byte
// Optional feature: define SPEECH_TIMEOUT_EN to add an ACK timeout with retry.
// With it, status bit3 becomes a sticky timeout flag instead of busy.
module speech_cmd_scheduler #(
    parameter int DEPTH_LOG2     = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       iCPC_CLOCK,
    input  logic       iRESET,
    input  logic       iWR_STROBE,
    input  logic [7:0] iCPC_DATA,
    input  logic       iSTATUS_CLEAR,
    input  logic       iATMEGA_ACK,
    input  logic       iATMEGA_READY,
    output logic [7:0] oATMEGA_DATA,
    output logic       oATMEGA_REQ,
    output logic       oFIFO_FULL,
    output logic [7:0] oSTATUS
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 2 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : gBadParams
        $error("speech_cmd_scheduler: illegal parameter value");
    end

    // Input synchronizers
    logic [SYNC_STAGES-1:0] wrSync, ackSync, readySync;
    logic                   wrPrev;

    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            wrSync    <= '0;
            ackSync   <= '0;
            readySync <= '0;
            wrPrev    <= 1'b0;
        end else begin
            wrSync    <= {wrSync[SYNC_STAGES-2:0], iWR_STROBE};
            ackSync   <= {ackSync[SYNC_STAGES-2:0], iATMEGA_ACK};
            readySync <= {readySync[SYNC_STAGES-2:0], iATMEGA_READY};
            wrPrev    <= wrSync[SYNC_STAGES-1];
        end
    end

    logic wrS, ackS, readyS;
    assign wrS    = wrSync[SYNC_STAGES-1];
    assign ackS   = ackSync[SYNC_STAGES-1];
    assign readyS = readySync[SYNC_STAGES-1];

    // One push per strobe, however long the CPC holds the write.
    logic push;
    assign push = wrS & ~wrPrev;

    // FIFO
    typedef enum logic [1:0] {IDLE, SETUP, REQ, RELEASE} state_t;
    state_t state;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  fifoFull, pop, pushOk, overflowSet;

    assign fifoFull    = (count == FULL_COUNT);
    assign pop         = (state == REQ) & ackS;
    // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign pushOk      = push & (~fifoFull | pop);
    assign overflowSet = push & fifoFull & ~pop;

    always_ff @(posedge iCPC_CLOCK) begin
        if (pushOk) begin
            mem[wptr] <= iCPC_DATA;
        end
    end

    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (pushOk) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + {{DEPTH_LOG2{1'b0}}, pushOk} - {{DEPTH_LOG2{1'b0}}, pop};
        end
    end

    // Handshake FSM
`ifdef SPEECH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] toCnt;
    logic            timeoutHit, timeoutFlag;
    assign timeoutHit = (state == REQ) & ~ackS & (toCnt == TO_LAST);
`endif

    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            state        <= IDLE;
            oATMEGA_REQ  <= 1'b0;
            oATMEGA_DATA <= 8'h00;
`ifdef SPEECH_TIMEOUT_EN
            toCnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    oATMEGA_REQ <= 1'b0;
                    if (count != '0) begin
                        oATMEGA_DATA <= mem[rptr];
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    oATMEGA_REQ <= 1'b1;
                    state       <= REQ;
`ifdef SPEECH_TIMEOUT_EN
                    toCnt       <= '0;
`endif
                end
                REQ: begin
                    if (ackS) begin
                        oATMEGA_REQ <= 1'b0;
                        state       <= RELEASE;
`ifdef SPEECH_TIMEOUT_EN
                    end else if (timeoutHit) begin
                        // Give up without popping; IDLE re-presents the same head byte.
                        oATMEGA_REQ <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        toCnt <= toCnt + 1'b1;
`endif
                    end
                end
                RELEASE: begin
                    oATMEGA_REQ <= 1'b0;
                    if (!ackS) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    oATMEGA_REQ <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    logic overflow;
    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            overflow <= 1'b0;
        end else if (overflowSet) begin
            overflow <= 1'b1;
        end else if (iSTATUS_CLEAR) begin
            overflow <= 1'b0;
        end
    end

    logic bit3;
`ifdef SPEECH_TIMEOUT_EN
    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            timeoutFlag <= 1'b0;
        end else if (timeoutHit) begin
            timeoutFlag <= 1'b1;
        end else if (iSTATUS_CLEAR) begin
            timeoutFlag <= 1'b0;
        end
    end
    assign bit3 = timeoutFlag;
`else
    assign bit3 = (state != IDLE);
`endif

    // Status byte: {ready, count[2:0], busy/timeout, overflow, full, empty}
    always_ff @(posedge iCPC_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            oSTATUS    <= 8'h01;
            oFIFO_FULL <= 1'b0;
        end else begin
            oSTATUS    <= {readyS, 3'(count), bit3, overflow, fifoFull, (count == '0)};
            oFIFO_FULL <= fifoFull;
        end
    end

endmodule

// File: doc/speech_cmd_scheduler.md
Name: speech_cmd_scheduler

Overview:
- Sequences CPC-to-ATmega speech command bytes.
- Captures bytes written by the CPC to the speech port into a small FIFO.
- Delivers each byte to the ATmega over a 4-phase REQ/ACK handshake, one byte at a time.
- Builds a status byte for CPC polling.
- Sits between the CPLD address decoder (speech-write strobe) and the ATmega data port. Replaces the single-byte latch with buffered, flow-controlled delivery.

Parameters:
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2. Legal range 1..2.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (iWR_STROBE, iATMEGA_ACK, iATMEGA_READY). Minimum 2.
- TIMEOUT_CYCLES, 4096, ACK timeout in iCPC_CLOCK cycles. Used only with SPEECH_TIMEOUT_EN.

Ports:
- iCPC_CLOCK  in  1  CPC 4 MHz clock; all state on its rising edge.
- iRESET  in  1  asynchronous, active-high reset.
- iWR_STROBE  in  1  active-high decoded speech-port IO write (IORQ&WR&address), asynchronous.
- iCPC_DATA  in  8  CPC data bus.
- iSTATUS_CLEAR  in  1  synchronous one-cycle pulse; clears sticky flags.
- iATMEGA_ACK  in  1  ATmega acknowledge, asynchronous.
- iATMEGA_READY  in  1  ATmega command-loop ready, asynchronous.
- oATMEGA_DATA  out  8  byte presented to the ATmega.
- oATMEGA_REQ  out  1  handshake request.
- oFIFO_FULL  out  1  FIFO full.
- oSTATUS  out  8  status byte for the CPC status read.

Behaviour:
- Reset:
  - FIFO emptied; overflow and timeout flags cleared; FSM forced to IDLE.
  - oATMEGA_REQ=0, oATMEGA_DATA=8'h00, oFIFO_FULL=0, oSTATUS=8'h01.
  - Reset asserted mid-handshake drops REQ immediately (asynchronous). Any in-flight byte is lost.
- Write capture:
  - iWR_STROBE passes through SYNC_STAGES flops. A rising edge of the synchronized signal produces a one-cycle push.
  - iCPC_DATA is sampled in the push cycle. The CPC holds data for the full IO write, which is at least 3 clocks.
  - Only one push per strobe, regardless of strobe length.
- FIFO: circular buffer with DEPTH_LOG2-bit pointers that wrap naturally; count is DEPTH_LOG2+1 bits.
  - Push when not full: write at wptr; wptr++; count++.
  - Push when full with no pop in the same cycle: byte discarded; overflow sticky flag set.
  - Push when full with a pop in the same cycle: accepted; count unchanged.
  - Simultaneous push and pop when not full or empty: count unchanged, both pointers advance.
  - Push into an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- Handshake FSM (ACK synchronized as ack_s):
  - IDLE: oATMEGA_REQ=0. If count!=0, latch head byte into oATMEGA_DATA, then go to SETUP.
  - SETUP: one cycle of data setup; then go to REQ.
  - REQ: oATMEGA_REQ=1. When ack_s=1, pop the FIFO and go to RELEASE.
  - RELEASE: oATMEGA_REQ=0. When ack_s=0, go to IDLE.
  - Latency from push (empty FIFO) to REQ high: 3 cycles.
  - oATMEGA_DATA holds its value from the SETUP entry until the next SETUP entry.
- Status byte:
  - bit0 empty
  - bit1 full
  - bit2 overflow (sticky)
  - bit3 busy (FSM != IDLE)
  - bits6:4 count, zero-extended
  - bit7 synchronized iATMEGA_READY
  - Registered: updated one cycle after the event.
- iSTATUS_CLEAR clears overflow and timeout flags. If a set event occurs in the same cycle as the clear, set wins.
- oFIFO_FULL = (count == 2**DEPTH_LOG2), registered together with the status byte.

Optional Feature:
- Macro SPEECH_TIMEOUT_EN.
- Enabled:
  - A counter runs while in REQ. If TIMEOUT_CYCLES elapse without ack_s, REQ is dropped and the FSM returns to IDLE without popping, so the same byte is retried.
  - A sticky timeout flag replaces status bit3. Busy is then unavailable on oSTATUS.
  - The counter clears on every REQ entry.
- Disabled: no counter logic; REQ waits indefinitely; bit3 = busy.

Test Plan:
1. Reset, then a single strobe with iCPC_DATA=8'hA5 -> after sync plus 3 cycles, oATMEGA_REQ=1 with oATMEGA_DATA=8'hA5. ACK=1 gives count 0; ACK=0 then returns oSTATUS=8'h01 (bit7 per READY).
2. Four strobes 8'h10..8'h13 with ACK held low -> oFIFO_FULL=1, oSTATUS[6:4]=4. A fifth strobe 8'h14 sets bit2 and is dropped. Delivered order is 10,11,12,13. iSTATUS_CLEAR then clears bit2.
3. FIFO full and a strobe synchronized in the same cycle as the pop on ack_s -> byte accepted, count stays 4, no overflow.
4. Assert iRESET while REQ=1 with 2 bytes queued -> REQ=0 asynchronously, oSTATUS=8'h01. No REQ after release until a new strobe.
5. 10-cycle-long strobe -> exactly one push, count=1.
6. With SPEECH_TIMEOUT_EN and TIMEOUT_CYCLES=16, push 8'h5A with no ACK -> REQ drops after 16 cycles, timeout bit3=1, REQ reasserts with 8'h5A. ACK completes delivery and count goes to 0.
